// File: rtl/fp_divider_pkg.sv
// fp_divider_pkg: shared fp32 constants, FSM encoding and operand unpacking for the float datapath.
// FP_DIV_SUBNORM_EN selects gradual underflow; otherwise subnormals flush to zero.
package fp_divider_pkg;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int EXP_IW = EXP_W + 2;
   localparam int BIAS   = 2**(EXP_W-1) - 1;
   localparam int Q_W    = MAN_W + 3;
   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam int DONE_B = 0;
   localparam int DZ_B   = 1;
   localparam int OV_B   = 2;
   localparam int INV_B  = 3;
   typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE, RELEASE} state_t;
   typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DIVZ, SP_INF, SP_ZERO} spec_t;
   typedef struct packed {
      logic                     nan;
      logic                     inf;
      logic                     zero;
      logic [MAN_W:0]           man;
      logic signed [EXP_IW-1:0] exp;
   } opnd_t;
   function automatic logic [4:0] lzc(input logic [MAN_W-1:0] f);
      lzc = 5'(MAN_W);
      for (int i = 0; i < MAN_W; i++) if (f[i]) lzc = 5'(MAN_W-1-i);
   endfunction
   function automatic opnd_t unpack(input logic [31:0] x);
      opnd_t o;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] f;
      e = x[MAN_W +: EXP_W];
      f = x[MAN_W-1:0];
      o.nan = &e && |f;
      o.inf = &e && f == '0;
`ifdef FP_DIV_SUBNORM_EN
      o.zero = e == '0 && f == '0;
      o.man  = e == '0 ? {f, 1'b0} << lzc(f) : {1'b1, f};
      o.exp  = e == '0 ? -$signed(EXP_IW'(lzc(f))) : $signed(EXP_IW'(e));
`else
      o.zero = e == '0;
      o.man  = {1'b1, f};
      o.exp  = $signed(EXP_IW'(e));
`endif
      return o;
   endfunction
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even of a 24-bit significand with guard/round/sticky.
// A subnormal that rounds up into the hidden bit is promoted to exponent 1.
module fp_round_rne
   import fp_divider_pkg::*;
(
   input  logic                     g_i,
   input  logic                     r_i,
   input  logic                     s_i,
   input  logic [MAN_W:0]           man_i,
   input  logic signed [EXP_IW-1:0] exp_i,
   output logic [MAN_W-1:0]         man_o,
   output logic signed [EXP_IW-1:0] exp_o
);
   logic           inc;
   logic           carry;
   logic [MAN_W+1:0] sum;
   always_comb begin
      inc   = g_i & (r_i | s_i | man_i[0]);
      sum   = {1'b0, man_i} + (MAN_W+2)'(inc);
      carry = sum[MAN_W+1];
      man_o = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
      exp_o = exp_i + EXP_IW'(carry | (exp_i == '0 && sum[MAN_W]));
   end
endmodule

// File: rtl/fp_divider.sv
// fp_divider: iterative restoring fp32 divider, fixed 29-cycle start-to-done latency, RNE.
// FP_DIV_SUBNORM_EN enables subnormal inputs/results; default build flushes them to zero.
module fp_divider
   import fp_divider_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_sig,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] result,
   output logic [3:0]  done_sig
);
   state_t                   state_q;
   spec_t                    spec_q, spec_d;
   opnd_t                    oa, ob;
   logic [31:0]              a_q, b_q, res_d;
   logic [3:0]               flg_d;
   logic                     sign_q, uf_q, uf_d, g_q, r_q, s_q, s_d, keep, ovf;
   logic [4:0]               cnt_q;
   logic [MAN_W:0]           mb_q, man_q;
   logic [Q_W-1:0]           rem_q, rem_d, quot_q, v, v_d;
   logic [Q_W:0]             trial;
   logic signed [EXP_IW-1:0] exp_q, en, exp_d, rexp;
   logic [MAN_W-1:0]         rman;
`ifdef FP_DIV_SUBNORM_EN
   logic signed [EXP_IW-1:0] k;
   logic [2*Q_W-1:0]         sv;
`endif
   fp_round_rne u_round (
      .g_i   (g_q),
      .r_i   (r_q),
      .s_i   (s_q),
      .man_i (man_q),
      .exp_i (exp_q),
      .man_o (rman),
      .exp_o (rexp)
   );
   always_comb begin
      oa     = unpack(a_q);
      ob     = unpack(b_q);
      spec_d = (oa.nan | ob.nan | (oa.inf & ob.inf) | (oa.zero & ob.zero)) ? SP_NAN :
               oa.inf ? SP_INF : ob.zero ? SP_DIVZ : (ob.inf | oa.zero) ? SP_ZERO : SP_NONE;
      trial  = {1'b0, rem_q} - {2'b0, mb_q};
      keep   = !trial[Q_W];
      rem_d  = (keep ? trial[Q_W-1:0] : rem_q) << 1;
      v      = quot_q[Q_W-1] ? quot_q : {quot_q[Q_W-2:0], 1'b0};
      en     = quot_q[Q_W-1] ? exp_q : exp_q - EXP_IW'(1);
`ifdef FP_DIV_SUBNORM_EN
      // shift below the normal range, folding every dropped bit into sticky
      k      = EXP_IW'(1) - en;
      sv     = {v, Q_W'(0)} >> (k > EXP_IW'(27) ? 5'd27 : k[4:0]);
      v_d    = en < EXP_IW'(1) ? sv[2*Q_W-1:Q_W] : v;
      s_d    = |rem_q | (en < EXP_IW'(1) && |sv[Q_W-1:0]);
      exp_d  = en < EXP_IW'(1) ? '0 : en;
      uf_d   = 1'b0;
`else
      v_d    = v;
      s_d    = |rem_q;
      exp_d  = en;
      uf_d   = en < EXP_IW'(1);
`endif
      ovf    = rexp >= EXP_IW'(255);
      flg_d         = '0;
      flg_d[DONE_B] = 1'b1;
      flg_d[INV_B]  = spec_q == SP_NAN;
      flg_d[DZ_B]   = spec_q == SP_DIVZ;
      flg_d[OV_B]   = spec_q == SP_NONE && !uf_q && ovf;
      res_d = flg_d[INV_B] ? QNAN :
              (spec_q == SP_ZERO || (spec_q == SP_NONE && uf_q)) ? {sign_q, 31'b0} :
              (spec_q == SP_NONE && !ovf) ? {sign_q, rexp[EXP_W-1:0], rman} :
              {sign_q, POS_INF[30:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result   <= '0;
         done_sig <= '0;
         a_q      <= '0;
         b_q      <= '0;
         spec_q   <= SP_NONE;
         sign_q   <= 1'b0;
         uf_q     <= 1'b0;
         exp_q    <= '0;
         mb_q     <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         cnt_q    <= '0;
         man_q    <= '0;
         g_q      <= 1'b0;
         r_q      <= 1'b0;
         s_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_sig) begin
               a_q     <= A;
               b_q     <= B;
               state_q <= UNPACK;
            end
            UNPACK: begin
               sign_q  <= a_q[31] ^ b_q[31];
               spec_q  <= spec_d;
               exp_q   <= oa.exp - ob.exp + EXP_IW'(BIAS);
               rem_q   <= Q_W'(oa.man);
               mb_q    <= ob.man;
               quot_q  <= '0;
               cnt_q   <= '0;
               state_q <= DIVIDE;
            end
            DIVIDE: begin
               quot_q  <= {quot_q[Q_W-2:0], keep};
               rem_q   <= rem_d;
               cnt_q   <= cnt_q + 5'd1;
               state_q <= cnt_q == 5'(Q_W-1) ? NORM : DIVIDE;
            end
            NORM: begin
               man_q   <= v_d[Q_W-1:2];
               g_q     <= v_d[1];
               r_q     <= v_d[0];
               s_q     <= s_d;
               exp_q   <= exp_d;
               uf_q    <= uf_d;
               state_q <= ROUND;
            end
            ROUND: begin
               result   <= res_d;
               done_sig <= flg_d;
               state_q  <= DONE;
            end
            DONE: begin
               done_sig <= '0;
               state_q  <= RELEASE;
            end
            RELEASE: if (!start_sig) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors for fp_divider (latency, results, flags, handshake, reset).
module tb_fp_divider;
   logic        clk = 1'b0;
   logic        rst, start_sig;
   logic [31:0] A, B, result;
   logic [3:0]  done_sig;
   int          errs = 0;
   int          checks = 0;
   int          pulses;
   fp_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start_sig (start_sig),
      .A         (A),
      .B         (B),
      .result    (result),
      .done_sig  (done_sig)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f);
      int n;
      @(negedge clk);
      A = a;
      B = b;
      start_sig = 1'b1;
      @(posedge clk);
      n = 0;
      @(negedge clk);
      A = ~a;
      B = ~b;
      while (n < 60) begin
         @(posedge clk);
         n++;
         #1;
         if (done_sig[0]) break;
      end
      check({tag, " latency"}, n, 29);
      check({tag, " result"}, result, r);
      check({tag, " flags"}, {28'b0, done_sig}, {28'b0, f});
      @(negedge clk);
      start_sig = 1'b0;
      @(posedge clk);
      #1 check({tag, " pulse"}, {28'b0, done_sig}, 32'd0);
      repeat (2) @(posedge clk);
   endtask
   initial begin
      rst = 1'b1;
      start_sig = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset result", result, 32'd0);
      check("reset done", {28'b0, done_sig}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("2.5/5",    32'h40200000, 32'h40A00000, 32'h3F000000, 4'b0001);
      run_op("x/x",      32'h40491687, 32'h40491687, 32'h3F800000, 4'b0001);
      run_op("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0001);
      run_op("-6/2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0001);
      run_op("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0011);
      run_op("-1/0",     32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0011);
      run_op("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1001);
      run_op("nan/1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1001);
      run_op("inf/inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1001);
      run_op("inf/2",    32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0001);
      run_op("2/-inf",   32'h40000000, 32'hFF800000, 32'h80000000, 4'b0001);
      run_op("max/0.25", 32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'b0101);
`ifdef FP_DIV_SUBNORM_EN
      run_op("min/2",    32'h00800000, 32'h40000000, 32'h00400000, 4'b0001);
`else
      run_op("min/2",    32'h00800000, 32'h40000000, 32'h00000000, 4'b0001);
`endif
      @(negedge clk);
      A = 32'h3F800000;
      B = 32'h40400000;
      start_sig = 1'b1;
      pulses = 0;
      repeat (35) begin
         @(posedge clk);
         #1 if (done_sig[0]) pulses++;
      end
      @(negedge clk);
      start_sig = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1 if (done_sig[0]) pulses++;
      end
      check("held start pulses", pulses, 1);
      check("held start result", result, 32'h3EAAAAAB);
      @(negedge clk);
      A = 32'h40200000;
      B = 32'h40A00000;
      start_sig = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      start_sig = 1'b0;
      @(posedge clk);
      #1;
      check("midop reset result", result, 32'd0);
      check("midop reset done", {28'b0, done_sig}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done_sig[0]) pulses++;
      end
      check("midop reset no done", pulses, 0);
      run_op("after reset", 32'h40200000, 32'h40A00000, 32'h3F000000, 4'b0001);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
